prefetch_unit: RTL and testbench

Parametrised instruction prefetch unit that replaces the hand-driven PC and single-register fetch in front of `decode`. It owns the program counter and issues in-order word requests to instruction memory through a valid/ready request channel. Returned instructions are buffered, each tagged with its PC, in a DEPTH-entry queue, and handed to decode over a valid/ready handshake. A redirect (branch/jump) flushes the queue and discards in-flight stale responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/inst_fifo.sv | 63 ++++++
 rtl/prefetch_unit.sv | 118 +++++++++++
 tb/tb_prefetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and default constants for the instruction prefetch path.
//   fetch_entry_t : one queued instruction together with the PC it came from
//   FETCH_DEPTH   : default queue depth (also the request credit limit)
//   RESET_PC      : default program counter after reset
package fetch_pkg;

    localparam int          FETCH_XLEN  = 32;
    localparam int          FETCH_ILEN  = 32;
    localparam int          FETCH_DEPTH = 4;
    localparam int unsigned RESET_PC    = 0;

    typedef struct packed {
        logic [FETCH_ILEN-1:0] inst;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo
// Synchronous DEPTH-entry FIFO holding packed fetch entries.
// Ports:
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   flush          : empties the FIFO (wins over push/pop)
//   push, push_data: write one entry at the tail
//   pop            : drop the head entry
//   head_data      : current head entry (storage is reset to 0)
//   count          : number of occupied entries, 0..DEPTH
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int WIDTH = $bits(fetch_entry_t)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = store[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit
// Owns the program counter, issues in-order word fetches to instruction
// memory and buffers the returned instructions (tagged with their PC) for
// decode. A redirect flushes the buffer and discards in-flight responses.
// Ports:
//   clock, reset_n                : rising-edge clock, synchronous active-low reset
//   enable                        : permits new memory requests
//   redirect_valid, redirect_pc   : one-cycle branch/jump strobe and target
//   mem_req_valid/ready/addr      : request channel to instruction memory
//   mem_resp_valid, mem_resp_data : in-order responses, always accepted
//   inst_valid/ready/data/pc      : queue head handed to decode
//   queue_count                   : occupied queue entries
module prefetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter int             ILEN     = 32,
    parameter int             DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::RESET_PC),
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [XLEN-1:0]        mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [ILEN-1:0]        mem_resp_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [ILEN-1:0]        inst_data,
    output logic [XLEN-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int             CW          = $clog2(DEPTH) + 1;
    localparam int             EW          = ILEN + XLEN;
    localparam logic [CW:0]    DEPTH_LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   outstanding_next;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head_data;

    // Queue slots plus in-flight requests never exceed DEPTH, so every
    // response has a slot waiting for it. Only registered state feeds this.
    assign credit_used   = {1'b0, queue_count} + {1'b0, outstanding};
    assign mem_req_valid = enable && (credit_used < DEPTH_LIMIT);
    assign mem_req_addr  = pc;

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign resp_fire = mem_resp_valid;

    // A response is live only when no stale ones remain and no redirect is
    // discarding it this very cycle.
    assign push = resp_fire && (drop == '0) && !redirect_valid;

    assign inst_valid = (queue_count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = head_data[EW-1:XLEN];
    assign inst_pc    = head_data[XLEN-1:0];

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);

    // On a redirect everything still in flight, including a request fired in
    // the same cycle, becomes stale; that is exactly the next outstanding count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc      <= redirect_pc;
                resp_pc <= redirect_pc;
                drop    <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc <= pc + PC_STEP;
                end
                if (resp_fire) begin
                    if (drop != '0) begin
                        drop <= drop - 1'b1;
                    end else begin
                        resp_pc <= resp_pc + PC_STEP;
                    end
                end
            end
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_inst_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({mem_resp_data, resp_pc}),
        .pop       (pop),
        .head_data (head_data),
        .count     (queue_count)
    );

endmodule

// File: tb/tb_prefetch_unit.sv
module tb_prefetch_unit;

    localparam int          XLEN   = 32;
    localparam int          ILEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  queue_count;

    prefetch_unit #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC),
        .PC_STEP  (32'd1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .queue_count    (queue_count)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks  = 0;
    int n_fail    = 0;
    int delivered = 0;

    // Reference: decode must see an unbroken run of sequential PCs starting
    // at the last reset/redirect target, each carrying mem[pc].
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] gen_pc;

    // Memory model: in-order responses with a configurable latency.
    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } mem_req_t;
    mem_req_t    pending[$];
    int unsigned mem_lat  = 1;
    int unsigned last_due = 0;
    int          credit   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h100 + a;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic top_up();
        while (sb.size() < 8) begin
            exp_t e;
            e.pc   = gen_pc;
            e.inst = mem_word(gen_pc);
            sb.push_back(e);
            gen_pc = gen_pc + 32'd1;
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        sb.delete();
        gen_pc = start;
        top_up();
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        top_up();
    endtask

    task automatic apply_stimulus(input logic en, input logic mrdy, input logic irdy);
        enable        = en;
        mem_req_ready = mrdy;
        inst_ready    = irdy;
    endtask

    // Request sampling and response bookkeeping happen mid-cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            pending.delete();
            credit   = 0;
            last_due = 0;
        end else begin
            if (mem_resp_valid) begin
                assert (credit > 0) else $error("[TB] response with no request outstanding");
                credit--;
            end
            if (mem_req_valid && mem_req_ready) begin
                mem_req_t r;
                r.due = cyc + mem_lat;
                if (r.due <= last_due) r.due = last_due + 1;
                last_due = r.due;
                r.addr   = mem_req_addr;
                pending.push_back(r);
                credit++;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
    end

    // Scoreboard monitor: pops one expectation per decode handshake.
    always @(negedge clock) begin
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL sb_underflow: got pc %h, expected no delivery", inst_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("inst_pc", inst_pc, e.pc);
                check_output("inst_data", inst_data, e.inst);
                delivered++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        restart_stream(RST_PC);

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clock);
        check_output("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_inst_data", inst_data, 32'd0);
        check_output("rst_inst_pc", inst_pc, 32'd0);
        check_output("rst_queue_count", 32'(queue_count), 32'd0);
        check_output("rst_mem_req_addr", mem_req_addr, RST_PC);

        // First-fetch latency and back-to-back delivery with 1-cycle memory
        next_cycle();
        reset_n = 1'b1;
        mem_lat = 1;
        apply_stimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check_output("latency_inst_valid", 32'(inst_valid), (i >= 2) ? 32'd1 : 32'd0);
            next_cycle();
        end

        // Decode stalled: queue fills and requests stop with nothing in flight
        inst_ready = 1'b0;
        for (int i = 0; i < 12; i++) next_cycle();
        @(negedge clock);
        check_output("full_queue_count", 32'(queue_count), 32'(DEPTH));
        check_output("full_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check_output("full_in_flight", 32'(pending.size()), 32'd0);
        next_cycle();
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) next_cycle();

        // 3-cycle memory, redirect with requests in flight
        mem_lat = 3;
        for (int i = 0; i < 10; i++) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        restart_stream(32'h40);
        @(negedge clock);
        check_output("redirect_masks_valid", 32'(inst_valid), 32'd0);
        base = delivered;
        for (int i = 0; i < 20; i++) next_cycle();
        check_output("after_redirect_progress", 32'(delivered > base), 32'd1);

        // Redirect coinciding with a request fire and a response
        mem_lat = 1;
        for (int i = 0; i < 8; i++) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        restart_stream(32'h80);
        for (int i = 0; i < 12; i++) next_cycle();

        // enable low: no requests, in-flight work still delivered
        mem_lat = 2;
        for (int i = 0; i < 4; i++) next_cycle();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_output("disabled_mem_req_valid", 32'(mem_req_valid), 32'd0);
            next_cycle();
        end
        @(negedge clock);
        check_output("disabled_in_flight", 32'(pending.size()), 32'd0);
        check_output("disabled_queue_drained", 32'(queue_count), 32'd0);
        next_cycle();
        enable = 1'b1;
        for (int i = 0; i < 12; i++) next_cycle();

        // One-cycle reset mid-stream
        reset_n = 1'b0;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        restart_stream(RST_PC);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        check_output("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check_output("midrst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("midrst_inst_data", inst_data, 32'd0);
        check_output("midrst_inst_pc", inst_pc, 32'd0);
        check_output("midrst_queue_count", 32'(queue_count), 32'd0);
        next_cycle();
        apply_stimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) next_cycle();

        // Randomized traffic
        base = delivered;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) mem_lat = $urandom_range(1, 3);
            reset_n = 1'b1;
            apply_stimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 399) == 0) begin
                reset_n    = 1'b0;
                inst_ready = 1'b0;
                restart_stream(RST_PC);
            end else if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom_range(0, 32'hFFF);
                restart_stream(redirect_pc);
            end
            next_cycle();
        end
        reset_n = 1'b1;
        check_output("random_progress", 32'((delivered - base) > 300), 32'd1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
